// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Registered program-counter sequencer. Each cycle it picks the next
//   instruction address from: sequential increment, branch target, jump
//   target, call target or return address. A small circular return-address
//   stack (RAS) serves call/ret, and a two-state RUN/HALT machine freezes the
//   sequencer once a halt instruction retires (only reset leaves HALT).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   stall      hold all state this cycle (highest priority)
//   br_taken   conditional branch resolved taken, go to br_target
//   br_target  branch destination
//   jmp        unconditional jump to jmp_target
//   call       push pc+1 and go to jmp_target
//   jmp_target jump/call destination
//   ret        pop the RAS into pc
//   halt       halt instruction at the current pc
//   pc         current instruction address (registered)
//   ras_depth  number of valid RAS entries, 0..RAS_DEPTH
//   ras_ovf    sticky: call made while the RAS was full
//   ras_unf    sticky: ret made while the RAS was empty
//   halted     sequencer is in HALT
module pc_sequencer #(
  parameter int              PC_W      = 7,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         br_taken,
  input  logic [PC_W-1:0]              br_target,
  input  logic                         jmp,
  input  logic                         call,
  input  logic [PC_W-1:0]              jmp_target,
  input  logic                         ret,
  input  logic                         halt,
  output logic [PC_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_depth,
  output logic                         ras_ovf,
  output logic                         ras_unf,
  output logic                         halted
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int DEP_W = PTR_W + 1;
  localparam logic [DEP_W-1:0] DEPTH_FULL = DEP_W'(RAS_DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [PTR_W-1:0]   top_reg, top_next;
  logic [DEP_W-1:0]   depth_reg, depth_next;
  logic               ovf_reg, ovf_next;
  logic               unf_reg, unf_next;

  logic               push_en;
  logic [PTR_W-1:0]   push_addr;
  logic [PC_W-1:0]    pc_inc;

  // Return-address storage. Contents need no reset: an entry is only read
  // once a push has written it (depth tracks validity).
  logic [PC_W-1:0]    ras_mem [RAS_DEPTH];

  assign pc_inc    = pc_reg + 1'b1;
  // Push pre-increments the top pointer; when the stack is full this wraps
  // onto the oldest entry, which is exactly the overwrite we want.
  assign push_addr = top_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_mem[push_addr] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
      top_reg   <= '0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      top_reg   <= top_next;
      depth_reg <= depth_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Next-state: strict priority stall > halt > ret > call > jmp > br_taken
  // > sequential. Lower-priority requests in the same cycle are dropped.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    top_next   = top_reg;
    depth_next = depth_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    push_en    = 1'b0;

    if (state_reg == RUN && !stall) begin
      if (halt) begin
        // pc stays on the halt instruction
        state_next = HALT;
      end else if (ret) begin
        if (depth_reg != '0) begin
          pc_next    = ras_mem[top_reg];
          top_next   = top_reg - 1'b1;
          depth_next = depth_reg - 1'b1;
        end else begin
          pc_next  = pc_inc;
          unf_next = 1'b1;
        end
      end else if (call) begin
        push_en  = 1'b1;
        top_next = push_addr;
        pc_next  = jmp_target;
        if (depth_reg == DEPTH_FULL) begin
          ovf_next = 1'b1;
        end else begin
          depth_next = depth_reg + 1'b1;
        end
      end else if (jmp) begin
        pc_next = jmp_target;
      end else if (br_taken) begin
        pc_next = br_target;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  assign pc        = pc_reg;
  assign ras_depth = depth_reg;
  assign ras_ovf   = ovf_reg;
  assign ras_unf   = unf_reg;
  assign halted    = (state_reg == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer (PC_W=7, RAS_DEPTH=4, RESET_PC=0).
//   Directed scenarios compare against hand-derived constants; a randomized
//   run compares every cycle against a queue-based reference model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic [6:0] br_target = '0;
  logic       jmp = 1'b0;
  logic       call = 1'b0;
  logic [6:0] jmp_target = '0;
  logic       ret = 1'b0;
  logic       halt = 1'b0;
  logic [6:0] pc;
  logic [2:0] ras_depth;
  logic       ras_ovf;
  logic       ras_unf;
  logic       halted;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [6:0] m_pc;
  logic [6:0] m_ras[$];
  logic       m_ovf, m_unf, m_halted;

  pc_sequencer #(.PC_W(7), .RAS_DEPTH(4), .RESET_PC(7'd0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jmp(jmp), .call(call), .jmp_target(jmp_target),
    .ret(ret), .halt(halt), .pc(pc), .ras_depth(ras_depth),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_pc = 7'd0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_halted = 1'b0;
  endtask

  // Behavioural rule set: what the next pc/stack/flags should be.
  task automatic model_step(input logic s, input logic h, input logic r,
                            input logic c, input logic j, input logic b,
                            input logic [6:0] jt, input logic [6:0] bt);
    if (m_halted || s) return;
    if (h) m_halted = 1'b1;
    else if (r) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = m_pc + 7'd1; m_unf = 1'b1; end
    end else if (c) begin
      m_ras.push_back(m_pc + 7'd1);
      if (m_ras.size() > 4) begin void'(m_ras.pop_front()); m_ovf = 1'b1; end
      m_pc = jt;
    end else if (j) m_pc = jt;
    else if (b) m_pc = bt;
    else m_pc = m_pc + 7'd1;
  endtask

  // Drive one cycle of requests, advance the model, sample 1 ns after the edge.
  task automatic cycle(input logic s, input logic h, input logic r,
                       input logic c, input logic j, input logic b,
                       input logic [6:0] jt, input logic [6:0] bt);
    stall = s; halt = h; ret = r; call = c; jmp = j; br_taken = b;
    jmp_target = jt; br_target = bt;
    model_step(s, h, r, c, j, b, jt, bt);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 7'd0, 7'd0);
  endtask

  task automatic do_reset();
    stall = 0; halt = 0; ret = 0; call = 0; jmp = 0; br_taken = 0;
    rst_n = 1'b0;
    model_reset();
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic advance_to(input logic [6:0] target);
    for (int k = 0; k < 200 && pc !== target; k++) idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc, ras_depth, ras_ovf, ras_unf, halted} !== 13'd0) begin
      errors++;
      $display("FAIL reset_values got pc=%0d depth=%0d ovf=%0b unf=%0b halted=%0b exp all 0",
               pc, ras_depth, ras_ovf, ras_unf, halted);
    end
    do_reset();
    checks++;
    if (pc !== 7'd0) begin errors++; $display("FAIL reset_release_pc got=%0d exp=0", pc); end
    idle();
    checks++;
    if (pc !== 7'd1) begin errors++; $display("FAIL first_update_pc got=%0d exp=1", pc); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 130; i++) begin
      idle();
      checks++;
      if (pc !== 7'((i + 1) % 128)) begin
        errors++;
        $display("FAIL seq_pc cycle=%0d got=%0d exp=%0d", i, pc, (i + 1) % 128);
      end
    end
    checks++;
    if ({ras_depth, ras_ovf, ras_unf, halted} !== 6'd0) begin
      errors++;
      $display("FAIL seq_flags got depth=%0d ovf=%0b unf=%0b halted=%0b exp 0",
               ras_depth, ras_ovf, ras_unf, halted);
    end
    $display("test_sequential done");
  endtask

  task automatic test_branch_jump();
    do_reset();
    advance_to(7'd5);
    cycle(0, 0, 0, 0, 0, 1, 7'd0, 7'd40);
    checks++;
    if (pc !== 7'd40) begin errors++; $display("FAIL br_taken got=%0d exp=40", pc); end
    idle();
    checks++;
    if (pc !== 7'd41) begin errors++; $display("FAIL br_after got=%0d exp=41", pc); end
    cycle(0, 0, 0, 0, 1, 1, 7'd10, 7'd99);
    checks++;
    if (pc !== 7'd10) begin errors++; $display("FAIL jmp_over_br got=%0d exp=10", pc); end
    $display("test_branch_jump done");
  endtask

  task automatic test_call_ret();
    logic [6:0] exp_pc [4];
    logic [2:0] exp_d  [4];
    exp_pc[0] = 7'd20; exp_pc[1] = 7'd30; exp_pc[2] = 7'd21; exp_pc[3] = 7'd4;
    exp_d[0] = 3'd1; exp_d[1] = 3'd2; exp_d[2] = 3'd1; exp_d[3] = 3'd0;
    do_reset();
    advance_to(7'd3);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) cycle(0, 0, 0, 1, 0, 0, (i == 0) ? 7'd20 : 7'd30, 7'd0);
      else       cycle(0, 0, 1, 0, 0, 0, 7'd0, 7'd0);
      checks++;
      if (pc !== exp_pc[i] || ras_depth !== exp_d[i]) begin
        errors++;
        $display("FAIL call_ret step=%0d got pc=%0d depth=%0d exp pc=%0d depth=%0d",
                 i, pc, ras_depth, exp_pc[i], exp_d[i]);
      end
    end
    // ret+call in one cycle: only the pop happens
    cycle(0, 0, 0, 1, 0, 0, 7'd60, 7'd0);
    cycle(0, 0, 1, 1, 0, 0, 7'd90, 7'd0);
    checks++;
    if (pc !== 7'd5 || ras_depth !== 3'd0) begin
      errors++;
      $display("FAIL ret_over_call got pc=%0d depth=%0d exp pc=5 depth=0", pc, ras_depth);
    end
    $display("test_call_ret done");
  endtask

  task automatic test_overflow();
    logic [6:0] exp_ret [4];
    exp_ret[0] = 7'd41; exp_ret[1] = 7'd31; exp_ret[2] = 7'd21; exp_ret[3] = 7'd11;
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 0, 7'((i + 1) * 10), 7'd0);
    checks++;
    if (pc !== 7'd50 || ras_depth !== 3'd4 || ras_ovf !== 1'b1 || ras_unf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_state got pc=%0d depth=%0d ovf=%0b unf=%0b exp pc=50 depth=4 ovf=1 unf=0",
               pc, ras_depth, ras_ovf, ras_unf);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 0, 0, 0, 7'd0, 7'd0);
      checks++;
      if (pc !== exp_ret[i] || ras_depth !== 3'(3 - i)) begin
        errors++;
        $display("FAIL ovf_ret step=%0d got pc=%0d depth=%0d exp pc=%0d depth=%0d",
                 i, pc, ras_depth, exp_ret[i], 3 - i);
      end
    end
    cycle(0, 0, 1, 0, 0, 0, 7'd0, 7'd0);
    checks++;
    if (pc !== 7'd12 || ras_unf !== 1'b1 || ras_depth !== 3'd0 || ras_ovf !== 1'b1) begin
      errors++;
      $display("FAIL unf_ret got pc=%0d unf=%0b depth=%0d ovf=%0b exp pc=12 unf=1 depth=0 ovf=1",
               pc, ras_unf, ras_depth, ras_ovf);
    end
    // stack wrap of the pushed return address: call at pc=127 pushes 0
    advance_to(7'd127);
    cycle(0, 0, 0, 1, 0, 0, 7'd7, 7'd0);
    cycle(0, 0, 1, 0, 0, 0, 7'd0, 7'd0);
    checks++;
    if (pc !== 7'd0) begin errors++; $display("FAIL ret_addr_wrap got=%0d exp=0", pc); end
    $display("test_overflow done");
  endtask

  task automatic test_stall();
    do_reset();
    cycle(0, 0, 0, 1, 0, 0, 7'd20, 7'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 0, 0, 7'd70, 7'd0);
      checks++;
      if (pc !== 7'd20 || ras_depth !== 3'd1 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
        errors++;
        $display("FAIL stall_call i=%0d got pc=%0d depth=%0d ovf=%0b unf=%0b exp pc=20 depth=1 flags 0",
                 i, pc, ras_depth, ras_ovf, ras_unf);
      end
    end
    cycle(1, 1, 0, 0, 0, 0, 7'd0, 7'd0);
    checks++;
    if (halted !== 1'b0 || pc !== 7'd20) begin
      errors++;
      $display("FAIL stall_halt got halted=%0b pc=%0d exp halted=0 pc=20", halted, pc);
    end
    idle();
    checks++;
    if (pc !== 7'd21) begin errors++; $display("FAIL after_stall got=%0d exp=21", pc); end
    $display("test_stall done");
  endtask

  task automatic test_halt_reset();
    do_reset();
    advance_to(7'd9);
    cycle(0, 1, 0, 0, 0, 0, 7'd0, 7'd0);
    checks++;
    if (halted !== 1'b1 || pc !== 7'd9) begin
      errors++;
      $display("FAIL halt_enter got halted=%0b pc=%0d exp halted=1 pc=9", halted, pc);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, i[0], ~i[0], 1, 7'd50, 7'd60);
      checks++;
      if (halted !== 1'b1 || pc !== 7'd9 || ras_depth !== 3'd0) begin
        errors++;
        $display("FAIL halt_hold i=%0d got halted=%0b pc=%0d depth=%0d exp 1/9/0",
                 i, halted, pc, ras_depth);
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 7'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got pc=%0d halted=%0b exp pc=0 halted=0", pc, halted);
    end
    do_reset();
    $display("test_halt_reset done");
  endtask

  task automatic test_random();
    int halt_cycles;
    logic s, h, r, c, j, b;
    halt_cycles = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_halted && halt_cycles > 3) begin
        do_reset();
        halt_cycles = 0;
      end
      s = ($urandom_range(99) < 15);
      h = ($urandom_range(99) < 3);
      r = ($urandom_range(99) < 25);
      c = ($urandom_range(99) < 25);
      j = ($urandom_range(99) < 15);
      b = ($urandom_range(99) < 20);
      cycle(s, h, r, c, j, b, 7'($urandom), 7'($urandom));
      if (m_halted) halt_cycles++;
      checks++;
      if ({pc, ras_depth, ras_ovf, ras_unf, halted} !==
          {m_pc, 3'(m_ras.size()), m_ovf, m_unf, m_halted}) begin
        errors++;
        $display("FAIL random cycle=%0d got pc=%0d depth=%0d ovf=%0b unf=%0b halted=%0b exp pc=%0d depth=%0d ovf=%0b unf=%0b halted=%0b",
                 i, pc, ras_depth, ras_ovf, ras_unf, halted,
                 m_pc, m_ras.size(), m_ovf, m_unf, m_halted);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_branch_jump();
    test_call_ret();
    test_overflow();
    test_stall();
    test_halt_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
